regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised integer register file for the core pipeline with N read ports,
//  optional same-cycle write->read bypass and a per-register busy scoreboard.
//  Clears the array on reset through a sequential CLEAR state, so no wide
//  single-cycle reset fan-out is needed. Sits between decode (reads, issue)
//  and writeback (write, busy release).
// PARAMETERS
//  XLEN    32  data width of each register
//  NREGS   32  number of architectural registers (power of 2, >=2); reg 0 hardwired 0
//  NREAD   2   number of read ports
//  BYPASS  1   1: a read of the register being written this cycle returns wr_data
//  AW      $clog2(NREGS)  address width (derived, not overridden)
// PORTS
//  clk        in   1           clock, all state updates on posedge
//  rst        in   1           synchronous, active-high reset
//  rd_addr    in   NREAD x AW  read addresses, port i = rd_addr[i]
//  rd_data    out  NREAD x XLEN  read data, combinational from rd_addr
//  rd_busy    out  NREAD       register at rd_addr[i] has a pending write
//  wr_en      in   1           writeback write strobe
//  wr_addr    in   AW          writeback destination
//  wr_data    in   XLEN        writeback data
//  iss_en     in   1           issue strobe: mark iss_addr busy
//  iss_addr   in   AW          destination register of issued instruction
//  ready      out  1           1 = CLEAR finished, ports are live
// BEHAVIOUR
//  - FSM states: CLEAR, RUN. rst=1 at an edge: state<=CLEAR, idx<=0, all busy<=0.
//  - CLEAR: each edge with rst=0 writes reg[idx]<=0, idx<=idx+1. The edge with
//    idx==NREGS-1 clears the last reg and sets state<=RUN. ready=1 only in RUN,
//    so ready rises exactly NREGS edges after rst falls.
//  - rst during CLEAR or RUN restarts CLEAR at idx 0; a partial clear is discarded.
//  - While ready=0: rd_data=0, rd_busy=0, and wr_en/iss_en are ignored.
//  - Reads (RUN): rd_data[i]=reg[rd_addr[i]]; addr 0 always returns 0.
//    If BYPASS=1 and wr_en and wr_addr==rd_addr[i]!=0: rd_data[i]=wr_data.
//  - Write (RUN): wr_en and wr_addr!=0 -> reg[wr_addr]<=wr_data at the next
//    edge. A write to reg 0 is dropped.
//  - Scoreboard (RUN), applied at the edge:
//    iss_en and iss_addr!=0 -> busy[iss_addr]<=1.
//    wr_en -> busy[wr_addr]<=0, unless iss_en with iss_addr==wr_addr
//    (issue wins; the new producer is pending). busy[0] is constant 0.
//  - rd_busy[i]=busy[rd_addr[i]], except BYPASS=1 and wr_en and
//    wr_addr==rd_addr[i] gives 0 (value supplied by bypass this cycle).
//    BYPASS=0: rd_busy reflects the registered busy bit only.
//  - Simultaneous write and read on different regs: no interaction.
//    All read ports are independent and may alias the same register.
//  - Reset values: ready=0, rd_busy=0, rd_data=0 throughout reset and CLEAR.
//  - No read latency; write and busy latency are 1 edge.
// TESTING
//  1 reset: rst 1 cycle, NREGS=32 -> ready=0 for 32 edges then 1; every
//    rd_addr reads 0 and rd_busy=0.
//  2 write/read: wr x5=0xDEADBEEF; next cycle rd_addr[0]=5 -> 0xDEADBEEF.
//    wr x0=0x1234 -> x0 reads 0.
//  3 bypass: BYPASS=1, same cycle wr x7=0xA5A5A5A5 and rd_addr[1]=7 ->
//    rd_data[1]=0xA5A5A5A5, rd_busy[1]=0. BYPASS=0 -> old value.
//  4 scoreboard: iss x3 -> rd_busy=1 next cycle. Same-cycle iss x3 and wr x3
//    -> busy stays 1. wr x3 alone -> busy 0. iss x0 -> never busy.
//  5 reset mid-CLEAR: rst at idx=10 -> ready stays 0 for 32 more edges.
//    wr_en during CLEAR has no effect after ready.
//  6 params: NREGS=64, NREAD=3, XLEN=64 -> ready after 64 edges;
//    3 ports read distinct/aliased regs correctly.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with N read ports, write->read bypass and a busy
// scoreboard; the array is zeroed by a sequential CLEAR walk after reset.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NREAD-1:0][AW-1:0]   rd_addr_i,
  output logic [NREAD-1:0][XLEN-1:0] rd_data_o,
  output logic [NREAD-1:0]           rd_busy_o,
  input  logic                       wr_en_i,
  input  logic [AW-1:0]              wr_addr_i,
  input  logic [XLEN-1:0]            wr_data_i,
  input  logic                       iss_en_i,
  input  logic [AW-1:0]              iss_addr_i,
  output logic                       ready_o
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic             run;

  assign run     = (state_q == S_RUN);
  assign ready_o = run;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    if (!run) begin
      idx_d = idx_q + AW'(1);
      if (idx_q == AW'(NREGS - 1)) state_d = S_RUN;
    end else begin
      if (wr_en_i) busy_d[wr_addr_i] = 1'b0;
      // issue applied last so a same-cycle new producer keeps the reg busy
      if (iss_en_i) busy_d[iss_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (!run) begin
        regs_q[idx_q] <= '0;
      end else if (wr_en_i && wr_addr_i != '0) begin
        regs_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rd_data_o[i] = '0;
      rd_busy_o[i] = 1'b0;
      if (run && rd_addr_i[i] != '0) begin
        if (BYPASS != 0 && wr_en_i && wr_addr_i == rd_addr_i[i]) begin
          rd_data_o[i] = wr_data_i;
        end else begin
          rd_data_o[i] = regs_q[rd_addr_i[i]];
          rd_busy_o[i] = busy_q[rd_addr_i[i]];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypass/no-bypass pair checked against an array model,
// plus a 64x64-bit three-port instance.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic             rst;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data0, rd_data1;
  logic [1:0]       busy0, busy1;
  logic             wr_en, iss_en, ready0, ready1;
  logic [4:0]       wr_addr, iss_addr;
  logic [31:0]      wr_data;

  logic             p_rst, p_wr_en, p_iss_en, p_ready;
  logic [2:0][5:0]  p_addr;
  logic [2:0][63:0] p_data;
  logic [2:0]       p_busy;
  logic [5:0]       p_wr_addr, p_iss_addr;
  logic [63:0]      p_wr_data;

  regfile_sb #(.BYPASS(1)) u0 (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data0),
    .rd_busy_o(busy0), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .ready_o(ready0));

  regfile_sb #(.BYPASS(0)) u1 (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data1),
    .rd_busy_o(busy1), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .ready_o(ready1));

  regfile_sb #(.XLEN(64), .NREGS(64), .NREAD(3)) u2 (
    .clk_i(clk), .rst_i(p_rst), .rd_addr_i(p_addr), .rd_data_o(p_data),
    .rd_busy_o(p_busy), .wr_en_i(p_wr_en), .wr_addr_i(p_wr_addr),
    .wr_data_i(p_wr_data), .iss_en_i(p_iss_en), .iss_addr_i(p_iss_addr),
    .ready_o(p_ready));

  // reference model: architectural contents, pending-write flags, and the
  // number of edges left before the file is usable
  logic [31:0] m_reg [32];
  bit          m_busy [32];
  int          m_clr = 32;

  task automatic model_edge();
    if (rst) begin
      m_clr = 32;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else if (m_clr > 0) begin
      m_clr--;
      if (m_clr == 0) foreach (m_reg[i]) m_reg[i] = '0;
    end else begin
      if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
      if (wr_en && !(iss_en && iss_addr == wr_addr)) m_busy[wr_addr] = 0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
    end
  endtask

  function automatic logic [31:0] exp_data(logic [4:0] a, bit byp);
    if (m_clr != 0 || a == 0) return '0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(logic [4:0] a, bit byp);
    if (m_clr != 0 || a == 0) return 1'b0;
    if (byp && wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 0; iss_en = 0; wr_addr = '0; iss_addr = '0; wr_data = '0;
  endtask

  task automatic clear_walk(string tag);
    for (int k = 0; k < 32; k++) begin
      rd_addr[0] = 5'($urandom); rd_addr[1] = 5'($urandom);
      wr_en = 1; wr_addr = 5'($urandom); wr_data = $urandom;
      iss_en = 1; iss_addr = 5'($urandom);
      #3;
      vectors++;
      if (ready0 !== 1'b0 || rd_data0 !== '0 || busy0 !== '0) begin
        errors++;
        $display("FAIL %s_clear edge %0d got rdy=%b d=%h b=%b exp 0", tag, k,
                 ready0, rd_data0, busy0);
      end
      step();
    end
    idle();
    vectors++;
    if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready got %b/%b exp 1", tag, ready0, ready1);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr[0] = 5'(a); rd_addr[1] = 5'(31 - a);
      #1;
      vectors++;
      if (rd_data0 !== '0 || busy0 !== '0 || rd_data1 !== '0) begin
        errors++;
        $display("FAIL %s_zero x%0d got %h b=%b exp 0", tag, a, rd_data0, busy0);
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1; step(); rst = 0;
    clear_walk("reset");
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; step();
    idle(); rd_addr[0] = 5; rd_addr[1] = 0; #1;
    vectors++;
    if (rd_data0[0] !== 32'hDEADBEEF || rd_data1[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_x5 got %h/%h exp deadbeef", rd_data0[0], rd_data1[0]);
    end
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234; step();
    idle(); rd_addr[0] = 0; #1;
    vectors++;
    if (rd_data0[0] !== '0 || rd_data1[0] !== '0) begin
      errors++;
      $display("FAIL wr_x0 got %h/%h exp 0", rd_data0[0], rd_data1[0]);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 7; wr_data = 32'h11110000; step();
    idle(); iss_en = 1; iss_addr = 7; step();
    idle();
    wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5; rd_addr[1] = 7; #1;
    vectors++;
    if (rd_data0[1] !== 32'hA5A5A5A5 || busy0[1] !== 1'b0) begin
      errors++;
      $display("FAIL byp1 got %h b=%b exp a5a5a5a5 b=0", rd_data0[1], busy0[1]);
    end
    vectors++;
    if (rd_data1[1] !== 32'h11110000 || busy1[1] !== 1'b1) begin
      errors++;
      $display("FAIL byp0 got %h b=%b exp 11110000 b=1", rd_data1[1], busy1[1]);
    end
    step(); idle(); #1;
    vectors++;
    if (rd_data1[1] !== 32'hA5A5A5A5 || busy1[1] !== 1'b0) begin
      errors++;
      $display("FAIL byp0_after got %h b=%b exp a5a5a5a5 b=0", rd_data1[1], busy1[1]);
    end
  endtask

  task automatic test_scoreboard();
    rd_addr[0] = 3; rd_addr[1] = 0;
    iss_en = 1; iss_addr = 3; step(); idle(); #1;
    vectors++;
    if (busy0[0] !== 1'b1 || busy1[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_iss got %b/%b exp 1", busy0[0], busy1[0]);
    end
    iss_en = 1; iss_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 32'h33;
    step(); idle(); #1;
    vectors++;
    if (busy0[0] !== 1'b1 || busy1[0] !== 1'b1 || rd_data0[0] !== 32'h33) begin
      errors++;
      $display("FAIL sb_iss_wr got %b/%b d=%h exp 1/1 d=33", busy0[0], busy1[0],
               rd_data0[0]);
    end
    wr_en = 1; wr_addr = 3; wr_data = 32'h44; step(); idle(); #1;
    vectors++;
    if (busy0[0] !== 1'b0 || busy1[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_wr got %b/%b exp 0", busy0[0], busy1[0]);
    end
    rd_addr[0] = 0; iss_en = 1; iss_addr = 0; step(); idle(); #1;
    vectors++;
    if (busy0[0] !== 1'b0 || busy1[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_x0 got %b/%b exp 0", busy0[0], busy1[0]);
    end
  endtask

  task automatic test_reset_mid_clear();
    idle(); rst = 1; step(); rst = 0;
    for (int k = 0; k < 10; k++) step();
    rst = 1; step(); rst = 0;
    clear_walk("midclr");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr_en = 1'($urandom); iss_en = 1'($urandom);
      wr_addr = 5'($urandom_range(0, 7)); iss_addr = 5'($urandom_range(0, 7));
      wr_data = $urandom;
      rd_addr[0] = 5'($urandom_range(0, 7)); rd_addr[1] = 5'($urandom_range(0, 7));
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (rd_data0[i] !== exp_data(rd_addr[i], 1) ||
            busy0[i] !== exp_busy(rd_addr[i], 1)) begin
          errors++;
          $display("FAIL rand_byp n%0d p%0d got %h b=%b exp %h b=%b", n, i,
                   rd_data0[i], busy0[i], exp_data(rd_addr[i], 1),
                   exp_busy(rd_addr[i], 1));
        end
        vectors++;
        if (rd_data1[i] !== exp_data(rd_addr[i], 0) ||
            busy1[i] !== exp_busy(rd_addr[i], 0)) begin
          errors++;
          $display("FAIL rand_nobyp n%0d p%0d got %h b=%b exp %h b=%b", n, i,
                   rd_data1[i], busy1[i], exp_data(rd_addr[i], 0),
                   exp_busy(rd_addr[i], 0));
        end
      end
      step();
    end
    idle();
  endtask

  task automatic test_params();
    logic [63:0] v [3];
    int n;
    p_wr_en = 0; p_iss_en = 0; p_wr_addr = '0; p_iss_addr = '0;
    p_wr_data = '0; p_addr = '0;
    p_rst = 1; step(); p_rst = 0;
    n = 0;
    while (!p_ready && n < 200) begin step(); n++; end
    vectors++;
    if (n != 64) begin
      errors++;
      $display("FAIL p_ready_edges got %0d exp 64", n);
    end
    v[0] = {$urandom, $urandom}; v[1] = {$urandom, $urandom};
    v[2] = {$urandom, $urandom};
    p_wr_en = 1;
    p_wr_addr = 10; p_wr_data = v[0]; step();
    p_wr_addr = 40; p_wr_data = v[1]; step();
    p_wr_addr = 63; p_wr_data = v[2]; step();
    p_wr_en = 0;
    p_addr[0] = 10; p_addr[1] = 40; p_addr[2] = 63; #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (p_data[i] !== v[i]) begin
        errors++;
        $display("FAIL p_distinct p%0d got %h exp %h", i, p_data[i], v[i]);
      end
    end
    p_iss_en = 1; p_iss_addr = 40; step(); p_iss_en = 0;
    p_addr[0] = 40; p_addr[1] = 40; p_addr[2] = 40; #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (p_data[i] !== v[1] || p_busy[i] !== 1'b1) begin
        errors++;
        $display("FAIL p_alias p%0d got %h b=%b exp %h b=1", i, p_data[i],
                 p_busy[i], v[1]);
      end
    end
  endtask

  initial begin
    foreach (m_reg[i]) m_reg[i] = '0;
    rst = 1; rd_addr = '0; idle();
    p_rst = 1; p_wr_en = 0; p_iss_en = 0; p_addr = '0;
    p_wr_addr = '0; p_iss_addr = '0; p_wr_data = '0;
    step();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_reset_mid_clear();
    test_random();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
